spi_receptor: RTL and testbench
===============================

SPI_RECEPTOR -- requirements
Module: spi_receptor

Interface
REQ-001 SHALL have parameter DATA_W, default 16: word length in bits, MSB first.
REQ-002 SHALL have port CLK, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port Reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port CKP, input, 1: SCK idle polarity; 0 = idle low, 1 = idle high.
REQ-005 SHALL have port CPH, input, 1: phase; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-006 SHALL have port SCK, input, 1: serial clock from the generator, asynchronous to CLK.
REQ-007 SHALL have port SS, input, 1: active-low slave select.
REQ-008 SHALL have port MOSI, input, 1: serial data in.
REQ-009 SHALL have port MISO, output, 1: serial data out.
REQ-010 SHALL have port tx_data, input, DATA_W: word to transmit.
REQ-011 SHALL have port tx_load, input, 1: one-cycle strobe that writes tx_data into the tx buffer.
REQ-012 SHALL have port rx_data, output, DATA_W: last complete received word.
REQ-013 SHALL have port rx_valid, output, 1: rx_data holds an unacknowledged word.
REQ-014 SHALL have port rx_ack, input, 1: consumer strobe that clears rx_valid.
REQ-015 SHALL have port busy, output, 1: high while a frame is in progress (state not IDLE).

Function
REQ-016 SHALL pass SCK, SS and MOSI through 2-flop synchronizers; SCK edges SHALL be detected from the synchronized value against a third delayed flop.
REQ-017 SHALL define the leading edge as rising when CKP=0 and falling when CKP=1; sample edge = leading if CPH=0, trailing if CPH=1; shift edge = the other edge.
REQ-018 SHALL latch CKP and CPH on the synchronized SS falling edge and hold them until SS rises; mid-frame changes SHALL have no effect.
REQ-019 SHALL implement the states IDLE -> LOAD (synchronized SS fall) -> SHIFT (next cycle) -> IDLE (synchronized SS rise, from any state).
REQ-020 In LOAD, the shift register SHALL copy the tx buffer and MISO SHALL present its MSB before the first SCK edge.
REQ-021 On each sample edge, MOSI SHALL be shifted into the rx shift register and the bit counter incremented; on each shift edge, the next tx bit SHALL drive MISO; the first shift edge with CPH=1 SHALL NOT advance MISO.
REQ-022 When the counter reaches DATA_W, rx_data SHALL be updated and rx_valid set in the same CLK cycle; the counter SHALL wrap to 0 and the tx shift register SHALL reload from the tx buffer, so that back-to-back words need no SS toggle.
REQ-023 rx_ack SHALL clear rx_valid on the next edge; if a completion and rx_ack occur in the same cycle, the completion SHALL win and rx_valid SHALL stay 1.
REQ-024 tx_load SHALL update the tx buffer at any time; a load during a frame SHALL take effect only at the next word boundary.
REQ-025 SS rising mid-word SHALL discard the partial word, leave rx_data and rx_valid unchanged, and clear the counter.
REQ-026 MISO SHALL be 0 while the state is IDLE.
REQ-027 Correct operation SHALL require an SCK half-period of at least 4 CLK periods and an SS setup of at least 4 CLK periods before the first SCK edge.

Reset
REQ-028 While Reset=0 at a CLK edge, the block SHALL clear the state (IDLE), counter, shift registers, tx buffer, rx_data, rx_valid, busy, MISO and overrun to 0 and its synchronizers to SCK=CKP and SS=1; a reset mid-frame SHALL abort the frame.

Configuration
REQ-029 With SPI_RX_OVERRUN_EN defined, the block SHALL have output overrun (1 bit), set when a word completes while rx_valid=1 and rx_ack=0 (the new word overwrites rx_data) and cleared only by Reset; without the macro, the port and its logic SHALL be absent.

Structure
REQ-030 Package spi_pkg SHALL hold the state encodings, the default DATA_W, and the mode constants (CKP/CPH pairs).
REQ-031 Sub-module spi_sync SHALL implement the synchronizer and edge detector, and SHALL be instantiated once each for SCK and SS.

Verification
REQ-032 Mode CKP=0, CPH=0: master sends 16'hA5C3, tx_data=16'h3C5A -> rx_data=16'hA5C3 and rx_valid=1; master captures 16'h3C5A.
REQ-033 All four modes, one frame each with 16'h8001 in both directions -> exact match in each mode.
REQ-034 Two back-to-back words 16'h1234 and 16'h5678 under one SS low, with rx_ack after the first -> two rx_valid rises, final rx_data=16'h5678.
REQ-035 SS raised after 7 bits -> rx_valid stays 0, busy falls, and the next full frame 16'hFFFF is received correctly.
REQ-036 Second word completes with no rx_ack -> rx_data holds the second word; overrun=1 with SPI_RX_OVERRUN_EN defined, no port without it.
REQ-037 Reset=0 asserted for 1 cycle after bit 9 -> all outputs 0, state IDLE; a new frame after SS re-select is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receptor: FSM encoding, default word
// length and the four (CKP, CPH) mode pairs.
package spi_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    typedef struct packed {
        logic ckp;
        logic cph;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{ckp: 1'b0, cph: 1'b0};
    localparam spi_mode_t MODE1 = '{ckp: 1'b0, cph: 1'b1};
    localparam spi_mode_t MODE2 = '{ckp: 1'b1, cph: 1'b0};
    localparam spi_mode_t MODE3 = '{ckp: 1'b1, cph: 1'b1};

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous input plus a third delayed flop
// used to flag rising and falling edges of the synchronized value.
module spi_sync (
    input  logic CLK,
    input  logic Reset,
    input  logic rst_val_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sr_q;
    logic [2:0] sr_d;

    assign sr_d = {sr_q[1:0], async_i};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            sr_q <= {3{rst_val_i}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign rise_o = sr_q[1] & ~sr_q[2];
    assign fall_o = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/spi_receptor.sv
// SPI slave with selectable CKP/CPH, back-to-back words under one SS and an
// rx_valid/rx_ack handshake. Define SPI_RX_OVERRUN_EN to add the sticky overrun flag.
module spi_receptor
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              CKP,
    input  logic              CPH,
    input  logic              SCK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
`ifdef SPI_RX_OVERRUN_EN
    output logic              overrun,
`endif
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic [1:0] mosi_q;
    logic mosi_s;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] rx_word;
    logic              rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d;
    logic              skip_q, skip_d;
    logic              ckp_q, ckp_d, cph_q, cph_d;
    logic              complete;
    logic              lead_edge, trail_edge, sample_edge, shift_edge;

    spi_sync u_sck_sync (
        .CLK       (CLK),
        .Reset     (Reset),
        .rst_val_i (CKP),
        .async_i   (SCK),
        .rise_o    (sck_rise),
        .fall_o    (sck_fall)
    );

    spi_sync u_ss_sync (
        .CLK       (CLK),
        .Reset     (Reset),
        .rst_val_i (1'b1),
        .async_i   (SS),
        .rise_o    (ss_rise),
        .fall_o    (ss_fall)
    );

    // MOSI shares the SCK synchronizer latency so a detected edge sees aligned data.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            mosi_q <= 2'b00;
        end else begin
            mosi_q <= {mosi_q[0], MOSI};
        end
    end
    assign mosi_s = mosi_q[1];

    assign lead_edge   = ckp_q ? sck_fall : sck_rise;
    assign trail_edge  = ckp_q ? sck_rise : sck_fall;
    assign sample_edge = cph_q ? trail_edge : lead_edge;
    assign shift_edge  = cph_q ? lead_edge  : trail_edge;
    assign rx_word     = {rx_sr_q, mosi_s};

    // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        miso_d    = miso_q;
        skip_d    = skip_q;
        ckp_d     = ckp_q;
        cph_d     = cph_q;
        complete  = 1'b0;
        tx_buf_d  = tx_load ? tx_data : tx_buf_q;

        if (ss_fall) begin
            ckp_d = CKP;
            cph_d = CPH;
        end

        if (ss_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
            skip_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    cnt_d  = '0;
                    if (ss_fall) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    // MISO carries the MSB now; tx_sr_q holds the bits still to present.
                    miso_d  = tx_buf_q[DATA_W-1];
                    tx_sr_d = tx_buf_q << 1;
                    rx_sr_d = '0;
                    cnt_d   = '0;
                    skip_d  = cph_q;
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sample_edge) begin
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            complete  = 1'b1;
                            rx_data_d = rx_word;
                            cnt_d     = '0;
                            tx_sr_d   = tx_buf_q;
                        end else begin
                            rx_sr_d = rx_word[DATA_W-2:0];
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            miso_d  = tx_sr_q[DATA_W-1];
                            tx_sr_d = tx_sr_q << 1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A completion outranks a simultaneous acknowledge.
        rx_valid_d = complete ? 1'b1 : (rx_ack ? 1'b0 : rx_valid_q);
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_buf_q   <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            skip_q     <= 1'b0;
            ckp_q      <= 1'b0;
            cph_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_buf_q   <= tx_buf_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
            skip_q     <= skip_d;
            ckp_q      <= ckp_d;
            cph_q      <= cph_d;
        end
    end

`ifdef SPI_RX_OVERRUN_EN
    logic overrun_q, overrun_d;

    assign overrun_d = overrun_q | (complete & rx_valid_q & ~rx_ack);

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_receptor.sv
// Directed bench for spi_receptor: a behavioural SPI master drives SCK/SS/MOSI
// in all four modes and captures MISO; results are checked with immediate assertions.
module tb_spi_receptor;
    import spi_pkg::*;

    localparam int H = 8;   // SCK half-period in CLK cycles

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        CKP = 1'b0, CPH = 1'b0, SCK = 1'b0, SS = 1'b1, MOSI = 1'b0;
    logic        MISO;
    logic [15:0] tx_data = '0;
    logic        tx_load = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ack = 1'b0;
    logic        busy;
`ifdef SPI_RX_OVERRUN_EN
    logic        overrun;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    spi_receptor #(.DATA_W(16)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .CKP      (CKP),
        .CPH      (CPH),
        .SCK      (SCK),
        .SS       (SS),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
`ifdef SPI_RX_OVERRUN_EN
        .overrun  (overrun),
`endif
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load_tx(input logic [15:0] v);
        @(negedge CLK);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge CLK);
        tx_load = 1'b0;
    endtask

    task automatic ack_rx();
        @(negedge CLK);
        rx_ack = 1'b1;
        @(negedge CLK);
        rx_ack = 1'b0;
    endtask

    task automatic select_slave(input logic ckp, input logic cph);
        CKP = ckp;
        CPH = cph;
        SCK = ckp;
        wait_clk(H);
        SS = 1'b0;
        wait_clk(H);
    endtask

    task automatic release_slave();
        SS = 1'b1;
        wait_clk(H);
    endtask

    // Master side: shifts nbits of mo out MSB first and collects MISO on each sample edge.
    task automatic xfer(input logic ckp, input logic cph, input logic [15:0] mo,
                        input int nbits, output logic [15:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cph) begin
                MOSI = mo[15-i];
                wait_clk(H);
                mi  = {mi[14:0], MISO};
                SCK = ~ckp;
                wait_clk(H);
                SCK = ckp;
            end else begin
                wait_clk(H);
                SCK  = ~ckp;
                MOSI = mo[15-i];
                wait_clk(H);
                mi  = {mi[14:0], MISO};
                SCK = ckp;
            end
        end
        wait_clk(H);
    endtask

    logic [15:0] cap;
    spi_mode_t   modes [4];

    initial begin
        modes[0] = MODE0; modes[1] = MODE1; modes[2] = MODE2; modes[3] = MODE3;

        // Reset state
        wait_clk(3);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_miso", 32'(MISO), 32'h0);
`ifdef SPI_RX_OVERRUN_EN
        check("reset_overrun", 32'(overrun), 32'h0);
`endif
        Reset = 1'b1;
        wait_clk(4);

        // Mode 0 basic exchange
        load_tx(16'h3C5A);
        select_slave(1'b0, 1'b0);
        check("m0_busy_in_frame", 32'(busy), 32'h1);
        xfer(1'b0, 1'b0, 16'hA5C3, 16, cap);
        check("m0_rx_data", 32'(rx_data), 32'hA5C3);
        check("m0_rx_valid", 32'(rx_valid), 32'h1);
        check("m0_miso_word", 32'(cap), 32'h3C5A);
        release_slave();
        check("m0_busy_after", 32'(busy), 32'h0);
        check("m0_miso_idle", 32'(MISO), 32'h0);
        ack_rx();
        check("m0_ack_clears", 32'(rx_valid), 32'h0);

        // One 8001 frame in each mode; mode 3 also changes CKP/CPH mid-frame
        for (int m = 0; m < 4; m++) begin
            load_tx(16'h8001);
            select_slave(modes[m].ckp, modes[m].cph);
            if (m == 3) begin
                CKP = 1'b0;
                CPH = 1'b0;
            end
            xfer(modes[m].ckp, modes[m].cph, 16'h8001, 16, cap);
            check($sformatf("mode%0d_rx_data", m), 32'(rx_data), 32'h8001);
            check($sformatf("mode%0d_rx_valid", m), 32'(rx_valid), 32'h1);
            check($sformatf("mode%0d_miso_word", m), 32'(cap), 32'h8001);
            release_slave();
            ack_rx();
        end

        // Back-to-back words; the mid-word tx load lands in the second word
        load_tx(16'h1234);
        select_slave(1'b0, 1'b0);
        load_tx(16'h5678);
        xfer(1'b0, 1'b0, 16'h1234, 16, cap);
        check("b2b_w1_rx_data", 32'(rx_data), 32'h1234);
        check("b2b_w1_rx_valid", 32'(rx_valid), 32'h1);
        check("b2b_w1_miso", 32'(cap), 32'h1234);
        check("b2b_busy_between", 32'(busy), 32'h1);
        ack_rx();
        check("b2b_ack_clears", 32'(rx_valid), 32'h0);
        xfer(1'b0, 1'b0, 16'h5678, 16, cap);
        check("b2b_w2_rx_data", 32'(rx_data), 32'h5678);
        check("b2b_w2_rx_valid", 32'(rx_valid), 32'h1);
        check("b2b_w2_miso", 32'(cap), 32'h5678);
        release_slave();
        ack_rx();

        // SS raised after 7 bits, then a full FFFF frame
        select_slave(1'b0, 1'b0);
        xfer(1'b0, 1'b0, 16'hFE00, 7, cap);
        release_slave();
        check("abort_rx_valid", 32'(rx_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_rx_data_kept", 32'(rx_data), 32'h5678);
        select_slave(1'b0, 1'b0);
        xfer(1'b0, 1'b0, 16'hFFFF, 16, cap);
        check("after_abort_rx_data", 32'(rx_data), 32'hFFFF);
        check("after_abort_rx_valid", 32'(rx_valid), 32'h1);
        release_slave();

        // Second word with FFFF still unacknowledged
`ifdef SPI_RX_OVERRUN_EN
        check("overrun_before", 32'(overrun), 32'h0);
`endif
        select_slave(1'b1, 1'b1);
        xfer(1'b1, 1'b1, 16'h0F0F, 16, cap);
        check("ovr_rx_data", 32'(rx_data), 32'h0F0F);
        check("ovr_rx_valid", 32'(rx_valid), 32'h1);
`ifdef SPI_RX_OVERRUN_EN
        check("overrun_set", 32'(overrun), 32'h1);
`endif
        release_slave();
        ack_rx();

        // One-cycle reset after bit 9 of a frame
        load_tx(16'hBEEF);
        select_slave(1'b0, 1'b0);
        xfer(1'b0, 1'b0, 16'hAAAA, 9, cap);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        check("mid_reset_rx_data", 32'(rx_data), 32'h0);
        check("mid_reset_rx_valid", 32'(rx_valid), 32'h0);
        check("mid_reset_busy", 32'(busy), 32'h0);
        check("mid_reset_miso", 32'(MISO), 32'h0);
`ifdef SPI_RX_OVERRUN_EN
        check("mid_reset_overrun", 32'(overrun), 32'h0);
`endif
        Reset = 1'b1;
        release_slave();
        check("post_reset_idle", 32'(busy), 32'h0);
        load_tx(16'h5AA5);
        select_slave(1'b0, 1'b1);
        xfer(1'b0, 1'b1, 16'hC3A5, 16, cap);
        check("post_reset_rx_data", 32'(rx_data), 32'hC3A5);
        check("post_reset_rx_valid", 32'(rx_valid), 32'h1);
        check("post_reset_miso", 32'(cap), 32'h5AA5);
        release_slave();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
